// File: rtl/deser7_pkg.sv
// Shared types and defaults for the deser7 serial-to-word deserializer.
package deser7_pkg;
  localparam int WORD_W          = 7;
  localparam int DEF_FRAME_WORDS = 8;
  localparam int DEF_MISS_LIMIT  = 2;

  typedef enum logic [1:0] {HUNT, LOCKED, CHECK} state_t;
endpackage

// File: rtl/sipo7.sv
// 7-bit serial-in/parallel-out shift register; new bits enter at bit 0.
module sipo7
  import deser7_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic              din,
  output logic [WORD_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr)
      q <= '0;
    else if (en)
      q <= {q[WORD_W-2:0], din};
  end

endmodule

// File: rtl/deser7.sv
// Frame-aligned 7-bit deserializer with sync-word hunt and lock.
// Optional periodic sync verification is built when DESER7_SYNC_CHECK_EN is defined.
module deser7
  import deser7_pkg::*;
#(
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int MISS_LIMIT  = DEF_MISS_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              din_valid,
  input  logic [WORD_W-1:0] sync_word,
  output logic [WORD_W-1:0] dataout,
  output logic              dout_valid,
  output logic              locked,
  output logic              sync_err
);

  state_t            state, state_n;
  logic [2:0]        bit_cnt, bit_n;
  logic [7:0]        word_cnt, word_n;
  logic [WORD_W-1:0] sr;
  logic [WORD_W-1:0] shifted;
  logic              load;

  sipo7 u_sipo (
    .clk (clk),
    .clr (rst),
    .en  (din_valid),
    .din (din),
    .q   (sr)
  );

  // Comparisons and word capture must see the bit arriving this cycle.
  assign shifted = {sr[WORD_W-2:0], din};
  assign locked  = (state == LOCKED) || (state == CHECK);

`ifdef DESER7_SYNC_CHECK_EN
  logic [3:0] miss_cnt, miss_n;
  logic       err;
`endif

  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    word_n  = word_cnt;
    load    = 1'b0;
`ifdef DESER7_SYNC_CHECK_EN
    miss_n  = miss_cnt;
    err     = 1'b0;
`endif
    if (din_valid) begin
      case (state)
        HUNT: begin
          if (bit_cnt >= 3'd6 && shifted == sync_word) begin
            state_n = LOCKED;
            bit_n   = 3'd0;
            word_n  = 8'd0;
          end else if (bit_cnt != 3'd7) begin
            bit_n = bit_cnt + 3'd1;
          end
        end
        LOCKED: begin
          if (bit_cnt == 3'd6) begin
            load  = 1'b1;
            bit_n = 3'd0;
            if (word_cnt == 8'(FRAME_WORDS - 1)) begin
              word_n = 8'd0;
`ifdef DESER7_SYNC_CHECK_EN
              state_n = CHECK;
`endif
            end else begin
              word_n = word_cnt + 8'd1;
            end
          end else begin
            bit_n = bit_cnt + 3'd1;
          end
        end
`ifdef DESER7_SYNC_CHECK_EN
        CHECK: begin
          if (bit_cnt == 3'd6) begin
            bit_n = 3'd0;
            if (shifted == sync_word) begin
              miss_n  = 4'd0;
              state_n = LOCKED;
            end else begin
              err = 1'b1;
              // Leaving for HUNT restarts the 7-bit minimum from scratch.
              if (miss_cnt + 4'd1 == 4'(MISS_LIMIT)) begin
                miss_n  = 4'd0;
                state_n = HUNT;
              end else begin
                miss_n  = miss_cnt + 4'd1;
                state_n = LOCKED;
              end
            end
          end else begin
            bit_n = bit_cnt + 3'd1;
          end
        end
`endif
        default: state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      bit_cnt    <= 3'd0;
      word_cnt   <= 8'd0;
      dataout    <= '0;
      dout_valid <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_n;
      word_cnt   <= word_n;
      dout_valid <= load;
      if (load)
        dataout <= shifted;
    end
  end

`ifdef DESER7_SYNC_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      miss_cnt <= 4'd0;
      err_q    <= 1'b0;
    end else begin
      miss_cnt <= miss_n;
      err_q    <= err;
    end
  end

  assign sync_err = err_q;
`else
  assign sync_err = 1'b0;
`endif

endmodule
